// File: rtl/i2s_tx_if.sv
// Sample FIFO write port and status bundle for i2s_tx.
// master = software/DMA side that fills the FIFO, slave = the transmitter.
interface i2s_tx_if #(
  parameter int AW = 4
) ();
  logic          fifo_wr;
  logic [31:0]   fifo_wdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   fifo_level;
  logic [AW:0]   fifo_level_threshold;
  logic          fifo_level_below;

  modport master (
    output fifo_wr, fifo_wdata, fifo_level_threshold,
    input  fifo_full, fifo_empty, fifo_level, fifo_level_below
  );

  modport slave (
    input  fifo_wr, fifo_wdata, fifo_level_threshold,
    output fifo_full, fifo_empty, fifo_level, fifo_level_below
  );
endinterface

// File: rtl/i2s_tx.sv
// I2S master transmitter: sck/ws generation, 32-sck slots, MSB-first serialisation
// of FIFO samples, standard I2S or left-justified framing, sticky underrun.
// Optional macro I2S_TX_REPEAT_ON_UNDERRUN_EN: an underrun slot resends the last
// value loaded for that channel instead of zeros.
module i2s_tx #(
  parameter int AW = 4
) (
  input  logic       clk,
  input  logic       rst,
  i2s_tx_if.slave    fif,
  output logic       ws,
  output logic       sck,
  output logic       sdo,
  output logic       underrun,
  input  logic       underrun_clr,
  input  logic       left_justified,
  input  logic [5:0] sample_size,
  input  logic [7:0] sck_prescaler,
  input  logic [1:0] channels,
  input  logic       en
);
  localparam int DEPTH = 1 << AW;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   level;

  logic [7:0]    presc;
  logic [4:0]    bit_ctr;
  logic [31:0]   sr, sr_nxt;
  logic          lj_q;

  logic          fall_tick, slot_start, new_ws, ch_on;
  logic          do_push, do_pop, ur_set, lj_eff;
  logic [5:0]    size_eff;
  logic [31:0]   rd_word;

`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
  logic [31:0]   hold_l, hold_r;
`endif

  // FIFO status; level never exceeds DEPTH so its top bit alone means full
  assign fif.fifo_full        = level[AW];
  assign fif.fifo_empty       = (level == '0);
  assign fif.fifo_level       = level;
  assign fif.fifo_level_below = (level < fif.fifo_level_threshold);

  // Tick/slot decode; the channel of a new slot is the ws value it is about to take
  assign fall_tick  = en & (presc == 8'd0) & sck;
  assign slot_start = fall_tick & (bit_ctr == 5'd0);
  assign new_ws     = ~ws;
  assign ch_on      = new_ws ? channels[0] : channels[1];
  assign do_pop     = slot_start & ch_on & ~fif.fifo_empty;
  assign ur_set     = slot_start & ch_on & fif.fifo_empty;
  assign do_push    = fif.fifo_wr & ~fif.fifo_full;
  assign size_eff   = (sample_size == 6'd0 || sample_size > 6'd32) ? 6'd32 : sample_size;
  assign rd_word    = mem[rptr];
  // framing mode is sampled at slot start; the starting tick already uses the new mode
  assign lj_eff     = slot_start ? left_justified : lj_q;

  // Next shift-register value: load at slot start, shift left on other falling ticks
  always_comb begin
    sr_nxt = sr;
    if (slot_start) begin
      if (do_pop)
        sr_nxt = rd_word << (6'd32 - size_eff);
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
      else if (ur_set)
        sr_nxt = new_ws ? hold_r : hold_l;
`endif
      else
        sr_nxt = '0;
    end else if (fall_tick) begin
      sr_nxt = {sr[30:0], 1'b0};
    end
  end

  // Clock generation, framing and serial output; disable returns these to reset values
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      presc   <= '0;
      sck     <= 1'b0;
      ws      <= 1'b1;
      bit_ctr <= '0;
      sr      <= '0;
      sdo     <= 1'b0;
      lj_q    <= 1'b0;
    end else begin
      if (presc == 8'd0) begin
        presc <= sck_prescaler;
        sck   <= ~sck;
      end else begin
        presc <= presc - 8'd1;
      end
      if (fall_tick) begin
        bit_ctr <= bit_ctr + 5'd1;
        sr      <= sr_nxt;
        // I2S mode sends the bit that left-justified mode sent one tick earlier
        sdo     <= lj_eff ? sr_nxt[31] : sr[31];
      end
      if (slot_start) begin
        ws   <= new_ws;
        lj_q <= left_justified;
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // FIFO storage, no reset needed since reads are gated by level
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= fif.fifo_wdata;
  end

  // Sticky underrun; a new underrun beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst)               underrun <= 1'b0;
    else if (ur_set)       underrun <= 1'b1;
    else if (underrun_clr) underrun <= 1'b0;
  end

`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
  // Per-channel copy of the last value loaded from the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_l <= '0;
      hold_r <= '0;
    end else if (do_pop) begin
      if (new_ws) hold_r <= sr_nxt;
      else        hold_l <= sr_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: decodes the serial stream like a receiver and compares each
// slot against a queue-based model of FIFO pops, underrun and sample alignment.
module tb_i2s_tx;
  logic       clk = 1'b0;
  logic       rst, underrun_clr, left_justified, en;
  logic       ws, sck, sdo, underrun;
  logic [5:0] sample_size;
  logic [7:0] sck_prescaler;
  logic [1:0] channels;

  i2s_tx_if #(.AW(4)) fif ();

  i2s_tx #(.AW(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .fif            (fif),
    .ws             (ws),
    .sck            (sck),
    .sdo            (sdo),
    .underrun       (underrun),
    .underrun_clr   (underrun_clr),
    .left_justified (left_justified),
    .sample_size    (sample_size),
    .sck_prescaler  (sck_prescaler),
    .channels       (channels),
    .en             (en)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [31:0] mq [$];
  logic        exp_ur;
  logic [31:0] hold_m [2];
  int          thr;

  // receiver/monitor state
  bit          mon_on = 1'b0;
  bit          cur_lj;
  bit          rise_seen;
  int          rise_cnt, ws_err, starts, cyc, last_rise, period;
  logic        sck_p, ws_p;
  logic [31:0] rx [64];

  // Receiver: samples sdo/ws on every sck rise, assigns bits to slots by count
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        cyc++;
        if (sck && !sck_p) begin
          int m, off, s, b;
          logic exp_ws;
          m = rise_cnt;
          rise_cnt++;
          if (rise_seen) period = cyc - last_rise;
          last_rise = cyc;
          rise_seen = 1'b1;
          if (m >= 1) begin
            exp_ws = (((m - 1) / 32) % 2) != 0;
            if (ws !== exp_ws) ws_err++;
          end
          off = cur_lj ? 1 : 2;
          if (m >= off) begin
            s = (m - off) / 32;
            b = (m - off) % 32;
            if (s < 64) rx[s][31 - b] = sdo;
          end
        end
        if (ws !== ws_p) starts++;
        sck_p = sck;
        ws_p  = ws;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    mq.delete();
    exp_ur    = 1'b0;
    hold_m[0] = '0;
    hold_m[1] = '0;
  endtask

  task automatic push(input logic [31:0] w);
    fif.fifo_wr    = 1'b1;
    fif.fifo_wdata = w;
    @(posedge clk);
    #1 fif.fifo_wr = 1'b0;
    if (mq.size() < 16) mq.push_back(w);
  endtask

  task automatic clr_ur();
    underrun_clr = 1'b1;
    @(posedge clk);
    #1 underrun_clr = 1'b0;
    exp_ur = 1'b0;
  endtask

  // Transmit ns slots with the given setup, then compare slots and FIFO state
  task automatic run(input int p, input bit lj, input int sz, input logic [1:0] ch,
                     input int ns, input string tag);
    int need, t, ss_eff, c;
    logic on;
    logic [31:0] w, e;
    sck_prescaler  = 8'(p);
    left_justified = lj;
    sample_size    = 6'(sz);
    channels       = ch;
    cur_lj         = lj;
    for (int i = 0; i < 64; i++) rx[i] = '0;
    rise_cnt = 0; ws_err = 0; starts = 0; cyc = 0; last_rise = 0; period = 0;
    rise_seen = 1'b0; sck_p = 1'b0; ws_p = 1'b1;
    mon_on = 1'b1;
    en     = 1'b1;
    need = 32 * ns + (lj ? 1 : 2);
    t = 0;
    while (rise_cnt < need && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 20000) chk({tag, "_timeout"}, rise_cnt, need);
    #1 en = 1'b0;
    @(negedge clk);
    #1 mon_on = 1'b0;
    ss_eff = (sz == 0 || sz > 32) ? 32 : sz;
    for (int s = 0; s < starts; s++) begin
      c  = s % 2;
      on = (c == 1) ? ch[0] : ch[1];
      e  = '0;
      if (on) begin
        if (mq.size() > 0) begin
          w = mq.pop_front();
          e = w << (32 - ss_eff);
          hold_m[c] = e;
        end else begin
          exp_ur = 1'b1;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
          e = hold_m[c];
`endif
        end
      end
      if (s < ns) chk($sformatf("%s_slot%0d", tag, s), rx[s], e);
    end
    @(posedge clk);
    #1;
    chk({tag, "_level"}, 32'(fif.fifo_level), mq.size());
    chk({tag, "_underrun"}, underrun, exp_ur);
    chk({tag, "_below"}, fif.fifo_level_below, mq.size() < thr);
    chk({tag, "_ws_timing"}, ws_err, 0);
    chk({tag, "_sck_period"}, period, 2 * (p + 1));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; underrun_clr = 1'b0; left_justified = 1'b0;
    sample_size = 6'd16; sck_prescaler = 8'd1; channels = 2'b11;
    fif.fifo_wr = 1'b0; fif.fifo_wdata = '0;
    thr = 1;
    fif.fifo_level_threshold = 5'(thr);
    do_reset();

    // reset state
    chk("rst_sck", sck, 1'b0);
    chk("rst_ws", ws, 1'b1);
    chk("rst_sdo", sdo, 1'b0);
    chk("rst_empty", fif.fifo_empty, 1'b1);
    chk("rst_level", 32'(fif.fifo_level), 0);
    chk("rst_underrun", underrun, 1'b0);

    // standard I2S, stereo, 16-bit
    push(32'h0000A5A5);
    push(32'h00003C3C);
    chk("i2s_level2", 32'(fif.fifo_level), 2);
    run(1, 1'b0, 16, 2'b11, 2, "i2s");
    clr_ur();

    // left-justified, same samples
    push(32'h0000A5A5);
    push(32'h00003C3C);
    run(1, 1'b1, 16, 2'b11, 2, "lj");
    clr_ur();

    // left only, 24-bit
    push(32'h00FFFFFF);
    push(32'h00FFFFFF);
    run(1, 1'b0, 24, 2'b10, 4, "left24");
    clr_ur();

    // empty FIFO stereo: underrun, then cleared by pulse
    run(0, 1'b0, 32, 2'b11, 2, "empty");
    clr_ur();
    chk("ur_cleared", underrun, 1'b0);

    // fill past full, threshold 5
    do_reset();
    thr = 5;
    fif.fifo_level_threshold = 5'(thr);
    for (int i = 0; i < 4; i++) push(32'h1000 + 32'(i));
    chk("lvl4", 32'(fif.fifo_level), 4);
    chk("below4", fif.fifo_level_below, 1'b1);
    push(32'h1004);
    chk("lvl5", 32'(fif.fifo_level), 5);
    chk("below5", fif.fifo_level_below, 1'b0);
    for (int i = 5; i < 17; i++) push($urandom);
    chk("full", fif.fifo_full, 1'b1);
    chk("lvl16", 32'(fif.fifo_level), 16);
    run(0, 1'b0, 32, 2'b11, 18, "drain");
    clr_ur();

    // reset in the middle of a slot
    do_reset();
    sck_prescaler = 8'd0; left_justified = 1'b0; sample_size = 6'd32; channels = 2'b11;
    push(32'h12345678);
    en = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    push(32'h1); push(32'h2); push(32'h3);
    chk("mid_underrun", underrun, 1'b1);
    chk("mid_nonempty", fif.fifo_empty, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_sck", sck, 1'b0);
    chk("mrst_ws", ws, 1'b1);
    chk("mrst_sdo", sdo, 1'b0);
    chk("mrst_empty", fif.fifo_empty, 1'b1);
    chk("mrst_underrun", underrun, 1'b0);
    rst = 1'b0; en = 1'b0;
    mq.delete(); exp_ur = 1'b0; hold_m[0] = '0; hold_m[1] = '0;

    // randomized configurations
    for (int r = 0; r < 6; r++) begin
      int np;
      thr = $urandom_range(0, 16);
      fif.fifo_level_threshold = 5'(thr);
      np = $urandom_range(0, 10);
      for (int i = 0; i < np; i++) push($urandom);
      run($urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom_range(0, 40),
          2'($urandom_range(0, 3)), 6, $sformatf("rnd%0d", r));
      clr_ur();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
